sbqm_teller_sched: RTL and testbench

SBQM_TELLER_SCHED -- requirements
Module: sbqm_teller_sched

---
 rtl/sbqm_pkg.sv | 24 ++
 rtl/sbqm_teller_fsm.sv | 62 ++++++
 rtl/sbqm_teller_sched.sv | 102 ++++++++++
 tb/tb_sbqm_teller_sched.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sbqm_pkg.sv
// Shared types and constants for the bank-queue teller scheduler.
// Holds the teller state encoding, teller count and default call timeout.
package sbqm_pkg;

  localparam int unsigned NT          = 3;
  localparam int unsigned TIMEOUT_DEF = 15;
  localparam int unsigned ID_W        = 2;
  localparam int unsigned TKT_W       = 3;
  localparam int unsigned PCNT_W      = 3;
  localparam int unsigned WCNT_W      = 4;

  typedef enum logic [1:0] {
    ST_OFF   = 2'b00,
    ST_FREE  = 2'b01,
    ST_CALL  = 2'b10,
    ST_SERVE = 2'b11
  } teller_state_t;

  // Folds an index in 0..2*NT-2 back into 0..NT-1.
  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W:0] v);
    return (v >= (ID_W+1)'(NT)) ? ID_W'(v - (ID_W+1)'(NT)) : ID_W'(v);
  endfunction

endpackage

// File: rtl/sbqm_teller_fsm.sv
// One teller desk: OFF/FREE/CALL/SERVE state machine plus the call wait counter.
// timeout_c flags the cycle in which an unanswered call gives up.
module sbqm_teller_fsm #(
  parameter int unsigned TIMEOUT = sbqm_pkg::TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       on_duty,
  input  logic       tack,
  input  logic       tfree,
  input  logic       grant,
  output logic [1:0] state,
  output logic       timeout_c
);
  import sbqm_pkg::*;

  localparam logic [WCNT_W-1:0] LAST = WCNT_W'(TIMEOUT - 1);

  teller_state_t      st;
  logic [WCNT_W-1:0]  wcnt;

  assign state = st;

  // An arriving customer beats the timeout in the same cycle.
  assign timeout_c = (st == ST_CALL) && !tack && (wcnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st   <= ST_OFF;
      wcnt <= '0;
    end else begin
      case (st)
        ST_OFF: begin
          if (on_duty) st <= ST_FREE;
        end
        ST_FREE: begin
          if (!on_duty) begin
            st <= ST_OFF;
          end else if (grant) begin
            st   <= ST_CALL;
            wcnt <= '0;
          end
        end
        ST_CALL: begin
          // Duty changes only take effect once the call is resolved.
          if (tack) begin
            st <= ST_SERVE;
          end else if (timeout_c) begin
            st <= on_duty ? ST_FREE : ST_OFF;
          end else if (wcnt != LAST) begin
            wcnt <= wcnt + 1'b1;
          end
        end
        ST_SERVE: begin
          if (tfree) st <= on_duty ? ST_FREE : ST_OFF;
        end
        default: st <= ST_OFF;
      endcase
    end
  end

endmodule

// File: rtl/sbqm_teller_sched.sv
// Teller scheduler: round-robin grants free tellers to waiting customers,
// issues tickets and reports busy/staffed status and call no-shows.
module sbqm_teller_sched #(
  parameter int unsigned TIMEOUT = sbqm_pkg::TIMEOUT_DEF,
  parameter int unsigned NT      = sbqm_pkg::NT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [sbqm_pkg::PCNT_W-1:0]   pcount,
  input  logic [NT-1:0]                 on_duty,
  input  logic [NT-1:0]                 tack,
  input  logic [NT-1:0]                 tfree,
  output logic                          call,
  output logic [sbqm_pkg::ID_W-1:0]     call_id,
  output logic [sbqm_pkg::TKT_W-1:0]    ticket,
  output logic [NT-1:0]                 busy,
  output logic [1:0]                    tcount,
  output logic                          noshow
);
  import sbqm_pkg::*;

  logic [1:0]      st [NT];
  logic [NT-1:0]   timeout_v;
  logic [NT-1:0]   grant_v;
  logic [NT-1:0]   free_v;
  logic [NT-1:0]   call_v;
  logic [NT-1:0]   live_v;

  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] gnt_idx;
  logic [ID_W-1:0] cand;
  logic            gnt_found;
  logic [ID_W:0]   n_call;
  logic [ID_W:0]   n_live;

  for (genvar i = 0; i < NT; i++) begin : g_teller
    sbqm_teller_fsm #(.TIMEOUT(TIMEOUT)) u_teller (
      .clk       (clk),
      .rst       (rst),
      .on_duty   (on_duty[i]),
      .tack      (tack[i]),
      .tfree     (tfree[i]),
      .grant     (grant_v[i]),
      .state     (st[i]),
      .timeout_c (timeout_v[i])
    );

    // A FREE teller leaving duty this cycle is not offered a customer.
    assign free_v[i] = (st[i] == ST_FREE) && on_duty[i];
    assign call_v[i] = (st[i] == ST_CALL);
    assign live_v[i] = (st[i] != ST_OFF);
    assign busy[i]   = (st[i] == ST_CALL) || (st[i] == ST_SERVE);
  end

  // Population counts of outstanding calls and staffed tellers.
  always_comb begin
    n_call = '0;
    n_live = '0;
    for (int i = 0; i < NT; i++) begin
      n_call = n_call + (ID_W+1)'(call_v[i]);
      n_live = n_live + (ID_W+1)'(live_v[i]);
    end
  end

  assign tcount = (n_live > (ID_W+1)'(3)) ? 2'd3 : 2'(n_live);

  // Only call when more customers wait than are already being called.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    if (pcount > PCNT_W'(n_call)) begin
      for (int k = 0; k < NT; k++) begin
        cand = wrap_idx((ID_W+1)'(rr_ptr) + (ID_W+1)'(k));
        if (!gnt_found && free_v[cand]) begin
          gnt_found = 1'b1;
          gnt_idx   = cand;
        end
      end
    end
    grant_v = gnt_found ? (NT'(1) << gnt_idx) : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr  <= '0;
      ticket  <= '0;
      call    <= 1'b0;
      call_id <= '0;
      noshow  <= 1'b0;
    end else begin
      call   <= gnt_found;
      noshow <= |timeout_v;
      if (gnt_found) begin
        call_id <= gnt_idx;
        ticket  <= ticket + 1'b1;
        rr_ptr  <= wrap_idx((ID_W+1)'(gnt_idx) + (ID_W+1)'(1));
      end
    end
  end

endmodule

// File: tb/tb_sbqm_teller_sched.sv
// Bench for sbqm_teller_sched: directed scenarios followed by random traffic,
// all checked against a cycle-level reference model of the desk rules.
module tb_sbqm_teller_sched;

  localparam int TMO = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] pcount;
  logic [2:0] on_duty;
  logic [2:0] tack;
  logic [2:0] tfree;
  logic       call;
  logic [1:0] call_id;
  logic [2:0] ticket;
  logic [2:0] busy;
  logic [1:0] tcount;
  logic       noshow;

  int checks = 0;
  int errors = 0;

  // Reference model: per-teller flags rather than a state code.
  bit m_on      [3];
  bit m_calling [3];
  bit m_serving [3];
  int m_wait    [3];
  int m_rr;
  int m_tkt;
  bit e_call;
  bit e_noshow;
  int e_id;

  always #5 clk = ~clk;

  sbqm_teller_sched #(.TIMEOUT(TMO), .NT(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .pcount  (pcount),
    .on_duty (on_duty),
    .tack    (tack),
    .tfree   (tfree),
    .call    (call),
    .call_id (call_id),
    .ticket  (ticket),
    .busy    (busy),
    .tcount  (tcount),
    .noshow  (noshow)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_on[i] = 0; m_calling[i] = 0; m_serving[i] = 0; m_wait[i] = 0;
    end
    m_rr = 0; m_tkt = 0; e_call = 0; e_noshow = 0; e_id = 0;
  endtask

  // Applies one clock of the desk rules to the model using the current inputs.
  task automatic model_step();
    int ncall;
    int g;
    int j;
    ncall = 0;
    g = -1;
    for (int i = 0; i < 3; i++) if (m_calling[i]) ncall++;
    if (int'(pcount) > ncall) begin
      for (int k = 0; k < 3; k++) begin
        j = (m_rr + k) % 3;
        if (g < 0 && m_on[j] && !m_calling[j] && !m_serving[j] && on_duty[j]) g = j;
      end
    end
    e_noshow = 0;
    for (int i = 0; i < 3; i++) begin
      if (m_calling[i]) begin
        if (tack[i]) begin
          m_calling[i] = 0; m_serving[i] = 1;
        end else if (m_wait[i] == TMO - 1) begin
          m_calling[i] = 0; e_noshow = 1; m_on[i] = on_duty[i];
        end else begin
          m_wait[i]++;
        end
      end else if (m_serving[i]) begin
        if (tfree[i]) begin
          m_serving[i] = 0; m_on[i] = on_duty[i];
        end
      end else if (m_on[i]) begin
        if (!on_duty[i]) m_on[i] = 0;
        else if (g == i) begin
          m_calling[i] = 1; m_wait[i] = 0;
        end
      end else begin
        if (on_duty[i]) m_on[i] = 1;
      end
    end
    e_call = (g >= 0);
    if (g >= 0) begin
      e_id  = g;
      m_tkt = (m_tkt + 1) % 8;
      m_rr  = (g + 1) % 3;
    end
  endtask

  task automatic compare_all();
    logic [2:0] eb;
    int tc;
    tc = 0;
    for (int i = 0; i < 3; i++) begin
      eb[i] = m_calling[i] | m_serving[i];
      if (m_on[i]) tc++;
    end
    check("call", 8'(call), 8'(e_call));
    check("noshow", 8'(noshow), 8'(e_noshow));
    check("busy", 8'(busy), 8'(eb));
    check("tcount", 8'(tcount), 8'(tc));
    check("ticket", 8'(ticket), 8'(m_tkt));
    if (e_call) check("call_id", 8'(call_id), 8'(e_id));
  endtask

  // One clock: step the model, let the DUT clock, compare, drop pulses.
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
    tack  = '0;
    tfree = '0;
  endtask

  initial begin
    int got[$];
    int exp_t[9];
    int n;
    exp_t = '{1, 2, 3, 4, 5, 6, 7, 0, 1};

    rst = 1'b0; pcount = '0; on_duty = '0; tack = '0; tfree = '0;
    model_reset();
    #12;
    check("rst_call", 8'(call), 8'd0);
    check("rst_call_id", 8'(call_id), 8'd0);
    check("rst_ticket", 8'(ticket), 8'd0);
    check("rst_busy", 8'(busy), 8'd0);
    check("rst_tcount", 8'(tcount), 8'd0);
    check("rst_noshow", 8'(noshow), 8'd0);

    // All staffed, empty queue: no calls.
    @(negedge clk);
    rst = 1'b1; on_duty = 3'b111; pcount = 3'd0;
    cyc();
    check("up_tcount", 8'(tcount), 8'd3);
    repeat (19) cyc();

    // Three waiting: back-to-back calls to 0, 1, 2.
    pcount = 3'd3;
    cyc(); check("rr0_id", 8'(call_id), 8'd0); check("rr0_tkt", 8'(ticket), 8'd1);
    cyc(); check("rr1_id", 8'(call_id), 8'd1); check("rr1_tkt", 8'(ticket), 8'd2);
    cyc(); check("rr2_id", 8'(call_id), 8'd2); check("rr2_tkt", 8'(ticket), 8'd3);

    // Tellers 0 and 2 get customers; teller 1 times out.
    tack = 3'b101; pcount = 3'd0;
    cyc();
    repeat (12) cyc();
    check("pre_noshow", 8'(noshow), 8'd0);
    check("pre_busy1", 8'(busy[1]), 8'd1);
    cyc();
    check("noshow_pulse", 8'(noshow), 8'd1);
    check("noshow_busy1", 8'(busy[1]), 8'd0);
    check("noshow_tcount", 8'(tcount), 8'd3);

    // Arrival on the timeout cycle wins.
    tfree = 3'b001; cyc();
    pcount = 3'd1; cyc();
    check("t0_call_id", 8'(call_id), 8'd0);
    check("t0_ticket", 8'(ticket), 8'd4);
    pcount = 3'd0;
    repeat (14) cyc();
    tack = 3'b001; cyc();
    check("race_noshow", 8'(noshow), 8'd0);
    check("race_busy0", 8'(busy[0]), 8'd1);
    cyc();

    // Teller 2 goes off duty mid-service.
    on_duty = 3'b011;
    repeat (3) cyc();
    check("drop_tcount_hold", 8'(tcount), 8'd3);
    tfree = 3'b100; cyc();
    check("drop_tcount", 8'(tcount), 8'd2);
    check("drop_busy2", 8'(busy[2]), 8'd0);
    pcount = 3'd7;
    for (int c = 0; c < 12; c++) begin
      tack = 3'b111; tfree = 3'b111;
      cyc();
      if (call) check("no_grant_t2", 8'(call_id == 2'd2), 8'd0);
    end

    // Asynchronous reset while a call is pending.
    on_duty = 3'b111; pcount = 3'd1;
    n = 0;
    while (!call && n < 10) begin
      cyc();
      n++;
    end
    check("arst_setup_call", 8'(call), 8'd1);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("arst_call", 8'(call), 8'd0);
    check("arst_call_id", 8'(call_id), 8'd0);
    check("arst_ticket", 8'(ticket), 8'd0);
    check("arst_busy", 8'(busy), 8'd0);
    check("arst_tcount", 8'(tcount), 8'd0);
    check("arst_noshow", 8'(noshow), 8'd0);
    @(negedge clk);
    rst = 1'b1; pcount = 3'd0;
    cyc();
    check("rerel_tcount", 8'(tcount), 8'd3);
    check("rerel_busy", 8'(busy), 8'd0);

    // Nine calls show the ticket wrap.
    pcount = 3'd1;
    n = 0;
    while (got.size() < 9 && n < 60) begin
      tack = 3'b111; tfree = 3'b111;
      cyc();
      if (call) got.push_back(int'(ticket));
      n++;
    end
    check("nine_calls", 8'(got.size()), 8'd9);
    for (int i = 0; i < got.size(); i++) check("ticket_seq", 8'(got[i]), 8'(exp_t[i]));

    // Random traffic with alternating answer rates.
    for (int c = 0; c < 400; c++) begin
      pcount = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) on_duty = 3'($urandom);
      if ((c / 50) % 2 == 0) tack = 3'($urandom) & 3'($urandom);
      else tack = 3'($urandom) & 3'($urandom) & 3'($urandom) & 3'($urandom);
      tfree = 3'($urandom) & 3'($urandom);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
